// File: rtl/calc_cmd_sequencer.sv
// Feeder for the RPN calculator: buffers 20-bit command words, replays each
// complete start..done transaction gap-free on calc_data, and captures the result.
module calc_cmd_sequencer #(
  parameter int DEPTH = 16
) (
  input  logic        ck,
  input  logic        rst_l,
  input  logic [19:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] calc_data,
  input  logic [15:0] calc_result,
  input  logic        calc_protocolError,
  input  logic        calc_stackOverflow,
  input  logic        calc_dataOverflow,
  input  logic        calc_unexpectedDone,
  input  logic        calc_correct,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        seq_overrun,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_e;

  state_e        state_q, state_d;
  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] done_cnt_q, done_cnt_d;
  logic [19:0]   calc_data_q, calc_data_d;
  logic [15:0]   out_result_q, out_result_d;
  logic [4:0]    out_flags_q, out_flags_d;
  logic          out_valid_q, out_valid_d;
  logic          seq_overrun_q, seq_overrun_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          overrun;
  logic [19:0]   head;

  // No pass-through: a full FIFO refuses a word even if it pops this cycle.
  assign full    = (count_q == CW'(DEPTH));
  assign push    = in_valid && !full;
  assign pop     = (state_q == S_ISSUE);
  assign head    = mem_q[rd_ptr_q];
  assign overrun = full && (done_cnt_q == '0) && (state_q == S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    calc_data_d   = calc_data_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_valid_d   = out_valid_q;
    seq_overrun_d = overrun;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    done_cnt_d    = done_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        calc_data_d = '0;
        if (done_cnt_q != '0 && !out_valid_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A done word is buffered, so the head is always valid here.
        calc_data_d = head;
        if (head[19]) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        out_result_d = calc_result;
        out_flags_d  = {calc_correct, calc_unexpectedDone, calc_dataOverflow,
                        calc_stackOverflow, calc_protocolError};
        out_valid_d  = 1'b1;
        calc_data_d  = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Full with no done word can never drain: flush to escape the deadlock.
    if (overrun) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      done_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      done_cnt_d = done_cnt_q + CW'(push && in_word[19]) - CW'(pop && head[19]);
    end
  end

  // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
  always_ff @(posedge ck or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      done_cnt_q    <= '0;
      calc_data_q   <= '0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_valid_q   <= 1'b0;
      seq_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      done_cnt_q    <= done_cnt_d;
      calc_data_q   <= calc_data_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_valid_q   <= out_valid_d;
      seq_overrun_q <= seq_overrun_d;
    end
  end

  // NOTE: storage is left unreset; the pointers and count define which entries are live.
  always_ff @(posedge ck) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  assign in_ready    = !full;
  assign calc_data   = calc_data_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign out_valid   = out_valid_q;
  assign seq_overrun = seq_overrun_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_CAPTURE);

endmodule
